// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline boundaries: control bit positions
// and the field widths of each inter-stage register.
package cpu_pipe_pkg;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;

  // MEM/WB boundary: RegWrite + MemtoReg control, ReadData + ALUOut + WriteReg data
  localparam int MEM_WB_CTRL_W = 2;
  localparam int MEM_WB_DATA_W = 69;

  localparam int PIPE_MAX_DEPTH = 8;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: valid bit, control field (zeroed for bubbles) and data
// field (never cleared by flush, only by reset).
module pipe_stage
  import cpu_pipe_pkg::*;
#(
  parameter int CTRL_W = MEM_WB_CTRL_W,
  parameter int DATA_W = MEM_WB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              src_valid,
  input  logic [CTRL_W-1:0] src_ctrl,
  input  logic [DATA_W-1:0] src_data,
  input  logic              load,
  input  logic              flush,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= src_valid;
      ctrl  <= src_valid ? src_ctrl : '0;
      data  <= src_data;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Reusable pipeline boundary: DEPTH chained slots with valid/ready handshake,
// stall back-pressure, synchronous flush and bubble collapsing.
module pipe_reg_chain
  import cpu_pipe_pkg::*;
#(
  parameter int CTRL_W = MEM_WB_CTRL_W,
  parameter int DATA_W = MEM_WB_DATA_W,
  parameter int DEPTH  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic              v [DEPTH];
  logic [CTRL_W-1:0] c [DEPTH];
  logic [DATA_W-1:0] d [DEPTH];
  logic [DEPTH-1:0]  rdy;

  function automatic logic [OCC_W-1:0] popcount(input logic bits [DEPTH]);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + OCC_W'(bits[i]);
    return n;
  endfunction

  // Ready ripples from the output back: an empty slot always accepts, which
  // is what squeezes bubbles out while the consumer is stalled.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) rdy[k] = ~v[k] | rdy[k+1];
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              src_valid;
    logic [CTRL_W-1:0] src_ctrl;
    logic [DATA_W-1:0] src_data;

    if (k == 0) begin : g_head
      assign src_valid = in_valid & ~flush;
      assign src_ctrl  = in_ctrl;
      assign src_data  = in_data;
    end else begin : g_link
      assign src_valid = v[k-1];
      assign src_ctrl  = c[k-1];
      assign src_data  = d[k-1];
    end

    pipe_stage #(
      .CTRL_W(CTRL_W),
      .DATA_W(DATA_W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .src_valid(src_valid),
      .src_ctrl (src_ctrl),
      .src_data (src_data),
      .load     (rdy[k]),
      .flush    (flush),
      .valid    (v[k]),
      .ctrl     (c[k]),
      .data     (d[k])
    );
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1];
  assign out_ctrl  = c[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign occupancy = popcount(v);

endmodule

// File: doc/pipe_reg_chain.md
# pipe_reg_chain

Parametrised pipeline register chain with a valid/ready handshake, stall back-pressure, synchronous flush and bubble collapsing. It replaces the fixed per-boundary pipeline registers (IF/ID … MEM/WB) with one reusable block.
- Payload is split into a control field, zeroed whenever a slot holds a bubble, and a data field, held unchanged.
- DEPTH stages can be chained, for multi-cycle units or retimed boundaries.

## Interface
Parameters:
- CTRL_W, 2, control bits per slot (e.g. RegWrite, MemtoReg); forced to 0 in empty slots.
- DATA_W, 69, data bits per slot (e.g. ReadData 32 + ALUOut 32 + WriteReg 5).
- DEPTH, 1, number of register stages; legal range 1..8.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream slot holds a real instruction.
- in_ready  out  1  chain accepts the input this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- flush  in  1  synchronous kill of every slot.
- out_valid  out  1  last stage holds a real instruction.
- out_ready  in  1  downstream accepts this cycle; 0 means stall.
- out_ctrl  out  CTRL_W  last-stage control; 0 whenever out_valid = 0.
- out_data  out  DATA_W  last-stage data.
- occupancy  out  $clog2(DEPTH+1)  number of valid slots.

## Operation
- Each stage k (0 = input side, DEPTH-1 = output side) holds v[k], c[k] and d[k].
- Stage ready: rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready. For k < DEPTH-1, rdy[k] = ~v[k] | rdy[k+1].
  - This is a combinational chain, so bubbles collapse: an empty slot accepts even when downstream is stalled.
- in_ready = rdy[0] & ~flush.
- Stage k loads when rdy[k] = 1:
  - The source is stage k-1; for k = 0 the source is the input, with valid = in_valid & ~flush.
  - v[k] takes the source valid bit.
  - c[k] takes the source ctrl if that valid bit is 1, else 0.
  - d[k] always takes the source data.
- When rdy[k] = 0 the stage holds all its fields.
- Flush has priority over everything:
  - At the edge, all v[k] become 0 and all c[k] become 0.
  - d[k] is held.
  - The input offered on the flush cycle is dropped, since in_ready is 0.
- A transfer at the output in the flush cycle (out_valid = 1 and out_ready = 1) still counts; the consumer owns that item.
- occupancy is the popcount of v[], taken combinationally from registers.
- in_valid = 1 with in_ready = 0 means the producer must hold its payload. The chain never drops an item except on flush.

## Timing
- Reset (rst_n low, asynchronous): all v, c and d become 0. So out_valid = 0, out_ctrl = 0, out_data = 0, occupancy = 0, and in_ready = 1 as long as flush = 0.
- Release of rst_n is synchronised upstream; the first edge after release operates normally.
- Latency with no stalls: an input accepted at edge N appears at the output after edge N+DEPTH-1, i.e. DEPTH cycles, one per stage.
- Throughput is 1 item per cycle while out_ready = 1.
- Full chain (all v = 1) with out_ready = 0: in_ready = 0 and all state holds.
- Full chain with out_ready = 1: the chain shifts by one and accepts a new input in the same cycle.
- Empty chain with out_ready = 0: DEPTH items are accepted on consecutive cycles, then in_ready drops to 0.
- Reset asserted mid-stream clears all slots immediately; no partial items remain.
- Flush with rst_n high: out_valid = 0 from the next cycle. Refill then starts the cycle after flush deasserts.

## Structure
- Shared package cpu_pipe_pkg holds:
  - CTRL bit positions (CTRL_REGWRITE = 0, CTRL_MEMTOREG = 1);
  - per-boundary field widths (MEM_WB_CTRL_W = 2, MEM_WB_DATA_W = 69).
- Sub-module pipe_stage: one slot (v, c, d) with inputs src_valid, src_ctrl, src_data, load and flush.
  - pipe_reg_chain instantiates pipe_stage DEPTH times with a generate loop.
  - It also builds the rdy chain and the occupancy popcount.

## Test plan
- Reset: hold rst_n = 0 with arbitrary inputs. Required: out_valid = 0, out_ctrl = 0, out_data = 0, occupancy = 0. After release, in_ready = 1.
- Streaming, DEPTH = 3, out_ready = 1, inputs data 1..10 with ctrl = 2'b11 on consecutive cycles. Required: data 1 emerges 3 cycles after its acceptance, then one item per cycle in order, never dropped.
- Stall and fill, DEPTH = 3:
  - With out_ready = 0, push A, B, C. Required: in_ready = 0 after the third accept, occupancy = 3.
  - Raise out_ready. Required: A, B, C emerge in order, with a new D accepted in the same cycle A leaves.
- Bubble collapse, DEPTH = 3: push A, idle one cycle, push B with out_ready = 0. Required: occupancy reaches 2 and the bubble is squeezed out, so A and B sit in adjacent stages at the output end.
- Flush: with 3 valid slots, pulse flush for 1 cycle with in_valid = 1. Required: next cycle out_valid = 0, out_ctrl = 0, occupancy = 0; the flushed-cycle input is not present; out_data is unchanged.
- Async reset mid-stream: assert rst_n = 0 between clock edges with the chain full. Required: outputs become 0 before the next edge and nothing reappears after release.
